xor1_gate: RTL and testbench
============================

Name: xor1_gate

Overview:
- Bitwise XOR primitive with a combinational result and a registered, valid-qualified copy.
- Also keeps a saturating count of accepted samples whose registered result was non-zero.
- Used as the leaf logic cell in the datapath and as the reference block for gate-level bring-up.
- Combinational path is independent of clock and reset; the registered path and counter are synchronous to clk.

Parameters:
- WIDTH, 1, operand/result width in bits (1..64).
- CNT_W, 16, width of the hit counter (4..32).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- y  output  WIDTH  combinational a XOR b.
- in_valid  input  1  qualifies a/b for the registered path.
- y_q  output  WIDTH  registered a XOR b of the last accepted sample.
- out_valid  output  1  y_q holds a result captured on the previous edge.
- hit_cnt  output  CNT_W  saturating count of accepted samples with non-zero XOR.
- cnt_clr  input  1  synchronous clear of hit_cnt.

Behaviour:
- y = a ^ b, bitwise, purely combinational with zero cycle latency.
- y is unaffected by clk, rst, in_valid and cnt_clr.
- For WIDTH=1, y follows the truth table 00->0, 01->1, 10->1, 11->0.
- Reset: rst high at a rising edge sets y_q=0, out_valid=0 and hit_cnt=0. rst overrides every other input.
- Reset can assert mid-stream; the result for any sample accepted on that edge is discarded.
- Registered path:
  - On an edge with in_valid=1: y_q <= a ^ b and out_valid <= 1 (one cycle latency).
  - On an edge with in_valid=0: out_valid <= 0 and y_q holds its previous value.
  - No backpressure; every valid sample is accepted.
- Counter:
  - On an edge with in_valid=1 and (a ^ b) != 0: hit_cnt increments by 1.
  - It saturates at 2^CNT_W - 1 and never wraps.
  - cnt_clr=1 sets hit_cnt to 0 on that edge.
  - If cnt_clr and a counted sample occur on the same edge, the clear wins and hit_cnt becomes 0; that sample is not counted.
- X-handling: none. Inputs are assumed driven; no internal state other than y_q, out_valid and hit_cnt.
- All outputs are driven directly by registers or simple logic, with no extra pipeline stages.

Test Plan:
- WIDTH=1, no clock, sweep (a,b) = 00, 01, 10, 11 with 10 time units between changes -> y = 0, 1, 1, 0 within the same timestep as each change.
- Hold rst=1 for 2 cycles with in_valid=1, a=1, b=0 -> y=1 throughout; y_q=0, out_valid=0, hit_cnt=0 after each edge.
- After reset, in_valid=1 for 4 cycles with (a,b) = 00, 01, 10, 11:
  - y_q = 0, 1, 1, 0 one cycle after each sample.
  - out_valid=1 for those cycles.
  - hit_cnt ends at 2.
- in_valid drops to 0 for 1 cycle -> out_valid=0 and y_q holds its last value; hit_cnt unchanged.
- CNT_W=4, stream 20 samples with a=1, b=0 -> hit_cnt saturates at 15.
- Then assert cnt_clr together with one more counted sample -> hit_cnt=0.
- Assert rst in the middle of a valid stream -> next edge gives y_q=0, out_valid=0, hit_cnt=0; y still tracks a^b combinationally.

Source files
------------

// File: rtl/xor1_gate.sv
// Bitwise XOR cell: combinational result, registered valid-qualified copy,
// and a saturating count of accepted samples whose XOR is non-zero.
module xor1_gate #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  input  logic             in_valid,
  output logic [WIDTH-1:0] y_q,
  output logic             out_valid,
  output logic [CNT_W-1:0] hit_cnt,
  input  logic             cnt_clr
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] res_q, res_d;
  logic             vld_q, vld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hit;

  assign y   = a ^ b;
  assign hit = in_valid && (|y);

  always_comb begin
    res_d = res_q;
    vld_d = in_valid;
    cnt_d = cnt_q;
    if (in_valid) begin
      res_d = y;
    end
    // Clear takes priority over a hit on the same edge.
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (hit && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_q <= '0;
      vld_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      res_q <= res_d;
      vld_q <= vld_d;
      cnt_q <= cnt_d;
    end
  end

  assign y_q       = res_q;
  assign out_valid = vld_q;
  assign hit_cnt   = cnt_q;

endmodule

// File: tb/tb_xor1_gate.sv
// Directed bench for xor1_gate: a 1-bit instance with a 4-bit counter and an
// 8-bit instance sharing control signals.
module tb_xor1_gate;

  logic       clk;
  logic       clk_en;
  logic       rst;
  logic       in_valid;
  logic       cnt_clr;
  logic [0:0] a, b, y, y_q;
  logic       out_valid;
  logic [3:0] hit_cnt;
  logic [7:0] a8, b8, y8, y8_q;
  logic       out_valid8;
  logic [15:0] hit_cnt8;

  int tests;
  int fails;

  xor1_gate #(.WIDTH(1), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .y(y), .in_valid(in_valid),
    .y_q(y_q), .out_valid(out_valid), .hit_cnt(hit_cnt), .cnt_clr(cnt_clr)
  );

  xor1_gate #(.WIDTH(8), .CNT_W(16)) dut8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .y(y8), .in_valid(in_valid),
    .y_q(y8_q), .out_valid(out_valid8), .hit_cnt(hit_cnt8), .cnt_clr(cnt_clr)
  );

  initial begin
    clk = 1'b0;
    wait (clk_en);
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
    $display("[TB] %s obs=%0h exp=%0h", tag, obs, exp);
  endtask

  // Advance one rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] ab_vec [4];
    logic [0:0] y_exp  [4];
    logic [3:0] cnt_exp;
    tests = 0; fails = 0;
    clk_en = 1'b0; rst = 1'b0; in_valid = 1'b0; cnt_clr = 1'b0;
    a = '0; b = '0; a8 = '0; b8 = '0;
    ab_vec = '{2'b00, 2'b01, 2'b10, 2'b11};
    y_exp  = '{1'b0, 1'b1, 1'b1, 1'b0};

    // Combinational truth table with no clock running.
    for (int i = 0; i < 4; i++) begin
      {a, b} = ab_vec[i];
      #1;
      check($sformatf("comb_tt_%0d", i), 64'(y), 64'(y_exp[i]));
      #9;
    end
    a8 = 8'hA5; b8 = 8'h5A; #1; check("comb8_a5_5a", 64'(y8), 64'hFF);
    a8 = 8'hF0; b8 = 8'hFF; #1; check("comb8_f0_ff", 64'(y8), 64'h0F);
    a8 = 8'h3C; b8 = 8'h3C; #1; check("comb8_equal", 64'(y8), 64'h00);

    // Reset held two cycles with a valid, counting sample present.
    clk_en = 1'b1;
    rst = 1'b1; in_valid = 1'b1; a = 1'b1; b = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check($sformatf("rst_y_%0d", i), 64'(y), 64'd1);
      check($sformatf("rst_yq_%0d", i), 64'(y_q), 64'd0);
      check($sformatf("rst_ov_%0d", i), 64'(out_valid), 64'd0);
      check($sformatf("rst_cnt_%0d", i), 64'(hit_cnt), 64'd0);
    end

    // Four valid samples through the truth table.
    rst = 1'b0;
    a8 = 8'h81; b8 = 8'h03;
    cnt_exp = 4'd0;
    for (int i = 0; i < 4; i++) begin
      {a, b} = ab_vec[i];
      tick();
      if (y_exp[i] != 1'b0) cnt_exp = cnt_exp + 4'd1;
      check($sformatf("stream_yq_%0d", i), 64'(y_q), 64'(y_exp[i]));
      check($sformatf("stream_ov_%0d", i), 64'(out_valid), 64'd1);
      check($sformatf("stream_cnt_%0d", i), 64'(hit_cnt), 64'(cnt_exp));
    end
    check("stream8_yq", 64'(y8_q), 64'h82);
    check("stream8_cnt", 64'(hit_cnt8), 64'd4);

    // Idle cycle: y_q holds even though a^b is now 1.
    in_valid = 1'b0; a = 1'b1; b = 1'b0;
    tick();
    check("idle_ov", 64'(out_valid), 64'd0);
    check("idle_yq_hold", 64'(y_q), 64'd0);
    check("idle_cnt", 64'(hit_cnt), 64'd2);
    check("idle8_ov", 64'(out_valid8), 64'd0);

    // Saturation of the 4-bit counter from 2.
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check($sformatf("sat_cnt_%0d", i), 64'(hit_cnt), (i + 3 > 15) ? 64'd15 : 64'(i + 3));
    end
    check("sat_yq", 64'(y_q), 64'd1);

    // Clear coincident with a counted sample: clear wins.
    cnt_clr = 1'b1;
    tick();
    check("clr_win_cnt", 64'(hit_cnt), 64'd0);
    check("clr_win_ov", 64'(out_valid), 64'd1);
    cnt_clr = 1'b0;
    tick();
    check("after_clr_cnt", 64'(hit_cnt), 64'd1);

    // Reset mid-stream with a counted sample on the reset edge.
    a = 1'b0; b = 1'b1;
    tick();
    check("pre_midrst_cnt", 64'(hit_cnt), 64'd2);
    rst = 1'b1; a = 1'b1; b = 1'b0;
    tick();
    check("midrst_yq", 64'(y_q), 64'd0);
    check("midrst_ov", 64'(out_valid), 64'd0);
    check("midrst_cnt", 64'(hit_cnt), 64'd0);
    check("midrst8_cnt", 64'(hit_cnt8), 64'd0);
    a = 1'b1; b = 1'b1; #1;
    check("midrst_y_11", 64'(y), 64'd0);
    a = 1'b0; b = 1'b1; #1;
    check("midrst_y_01", 64'(y), 64'd1);
    rst = 1'b0;
    tick();
    check("post_rst_yq", 64'(y_q), 64'd1);
    check("post_rst_cnt", 64'(hit_cnt), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
